// File: rtl/dadda_pkg.sv
// Shared constants and FSM state type for the dadda multiplier arbiter.
package dadda_pkg;
  localparam int MUL_IN_W       = 8;
  localparam int MUL_OUT_W      = 16;
  localparam int DADDA8_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
// Returns a one-hot grant plus the encoded winner; found=0 when req is empty.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner,
  output logic               found
);
  localparam logic [ID_W:0] NUM = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= NUM) idx = idx - NUM;
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
    gnt[winner] = found;
  end
endmodule

// File: rtl/dadda_mul_arbiter.sv
// Round-robin share of one pipelined 8x8 multiplier; response MUL_LATENCY+1 cycles after accept, no backpressure.
// MUL_ARB_STATS_EN adds stat_grants, a saturating 16-bit accept counter per requester.
module dadda_mul_arbiter
  import dadda_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = DADDA8_LATENCY,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [MUL_IN_W*NUM_REQ-1:0]   req_a,
  input  logic [MUL_IN_W*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [MUL_IN_W-1:0]           mul_a,
  output logic [MUL_IN_W-1:0]           mul_b,
  input  logic [MUL_OUT_W-1:0]          mul_y,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [MUL_OUT_W-1:0]          resp_data,
  output logic [ID_W-1:0]               resp_id,
  output logic                          idle
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]         stat_grants
`endif
);
  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]      tag_id_q [MUL_LATENCY];
  logic [ID_W-1:0]      tag_id_d [MUL_LATENCY];
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [MUL_OUT_W-1:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;

  logic [MUL_IN_W-1:0]  a_arr [NUM_REQ];
  logic [MUL_IN_W-1:0]  b_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      winner;
  logic                 found;
  logic                 grant_en;
  logic                 accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*MUL_IN_W +: MUL_IN_W];
    assign b_arr[i] = req_b[i*MUL_IN_W +: MUL_IN_W];
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .winner(winner),
    .found (found)
  );

  // Grant looks at the live en, so dropping en blocks a same-cycle request.
  always_comb begin
    grant_en  = (state_q == RUN) && en && !rst;
    accept    = grant_en && found;
    req_ready = grant_en ? gnt : '0;
    mul_a     = accept ? a_arr[winner] : '0;
    mul_b     = accept ? b_arr[winner] : '0;
    ptr_d     = ptr_q;
    if (accept) ptr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = accept;
    tag_id_d[0]  = winner;
    for (int s = 1; s < MUL_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (tag_vld_q[MUL_LATENCY-1]) begin
      resp_valid_d[tag_id_q[MUL_LATENCY-1]] = 1'b1;
      resp_data_d = mul_y;
      resp_id_d   = tag_id_q[MUL_LATENCY-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = (|tag_vld_q) ? DRAIN : IDLE;
      DRAIN: begin
        if (en) state_d = RUN;
        else if (!(|tag_vld_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '{default: '0};
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign idle       = (state_q == IDLE);

`ifdef MUL_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q[winner] != 16'hFFFF)) cnt_d[winner] = cnt_q[winner] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else     cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    assign stat_grants[16*i +: 16] = cnt_q[i];
  end
`endif
endmodule
